// File: rtl/cp0_tlb_ctrl_if.sv
// TLB maintenance bus between cp0_tlb_ctrl (master) and the TLB array (slave).
// Carries the pipeline request handshake, the entry read/write port, the probe
// port and the current ASID. TLB_ENTRIES defaults to `TLB_ENTRIES_NUM (16).
`ifndef TLB_ENTRIES_NUM
`define TLB_ENTRIES_NUM 16
`endif

interface cp0_tlb_ctrl_if #(
    parameter int TLB_ENTRIES = `TLB_ENTRIES_NUM
);
    localparam int IW = $clog2(TLB_ENTRIES);

    typedef logic [IW-1:0] tlb_index_t;

    // One TLB entry; page_mask is carried for completeness but only 4 KB pages exist.
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [15:0] page_mask;
        logic [25:0] entry_lo0;
        logic [25:0] entry_lo1;
    } tlb_entry_t;

    logic        op_valid;
    logic [1:0]  op_type;
    logic        op_ready;
    logic        op_done;
    logic [7:0]  asid;
    tlb_index_t  tlbrw_index;
    logic        tlbrw_we;
    tlb_entry_t  tlbrw_wdata;
    tlb_entry_t  tlbrw_rdata;
    logic [31:0] tlbp_entry_hi;
    logic [31:0] tlbp_index;

    modport master (
        input  op_valid, op_type, tlbrw_rdata, tlbp_index,
        output op_ready, op_done, asid, tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi
    );

    modport slave (
        output op_valid, op_type, tlbrw_rdata, tlbp_index,
        input  op_ready, op_done, asid, tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi
    );
endinterface

// File: rtl/cp0_tlb_ctrl.sv
// CP0 TLB register file and TLBR/TLBWI/TLBWR/TLBP sequencer.
// Optional feature: define TLB_WIRED_EN to implement the Wired register; without
// it Wired reads 0 and Random cycles over the full [0, TLB_ENTRIES-1] range.
//
// state | meaning
// IDLE  | op_ready high, waiting for a request
// EXEC  | entry access on tlbrw_*/tlbp_*; write strobe or result capture
// DONE  | op_done pulse, captured registers visible
`ifndef TLB_ENTRIES_NUM
`define TLB_ENTRIES_NUM 16
`endif

module cp0_tlb_ctrl #(
    parameter int TLB_ENTRIES = `TLB_ENTRIES_NUM
) (
    input  logic                 clk,
    input  logic                 reset,
    cp0_tlb_ctrl_if.master       tlb,
    input  logic                 reg_we,
    input  logic [4:0]           reg_addr,
    input  logic [31:0]          reg_wdata,
    output logic [31:0]          reg_rdata,
    input  logic                 exc_we,
    input  logic [31:0]          exc_vaddr
);
    localparam int IW = $clog2(TLB_ENTRIES);
    localparam logic [IW-1:0] IDX_MAX = IW'(TLB_ENTRIES - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {OP_TLBR, OP_TLBWI, OP_TLBWR, OP_TLBP} op_t;

    state_t         state;
    op_t            op_q;
    op_t            op_in;
    logic           ready_q;
    logic           done_q;
    logic           we_q;
    logic [IW-1:0]  idx_q;
    logic [18:0]    wd_vpn2;
    logic [7:0]     wd_asid;
    logic [25:0]    wd_lo0;
    logic [25:0]    wd_lo1;

    logic [31:0]    index_q;
    logic [IW-1:0]  random_q;
    logic [25:0]    lo0_q;
    logic [25:0]    lo1_q;
    logic [18:0]    vpn2_q;
    logic [7:0]     asid_q;
    logic [IW-1:0]  wired_v;
    logic           wired_wr;

    assign op_in = op_t'(tlb.op_type);

`ifdef TLB_WIRED_EN
    logic [IW-1:0] wired_q;
    assign wired_wr = reg_we && (reg_addr == 5'd6);
    assign wired_v  = wired_q;

    // Wired register: MTC0-writable lower bound of the Random range.
    always_ff @(posedge clk) begin
        if (reset)         wired_q <= '0;
        else if (wired_wr) wired_q <= reg_wdata[IW-1:0];
    end
`else
    assign wired_wr = 1'b0;
    assign wired_v  = '0;
`endif

    // Request sequencer; write target and entry data are frozen at accept so
    // MTC0 traffic during EXEC cannot disturb the entry being written.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            op_q    <= OP_TLBR;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wd_vpn2 <= '0;
            wd_asid <= '0;
            wd_lo0  <= '0;
            wd_lo1  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tlb.op_valid) begin
                        state   <= S_EXEC;
                        op_q    <= op_in;
                        ready_q <= 1'b0;
                        we_q    <= (op_in == OP_TLBWI) || (op_in == OP_TLBWR);
                        idx_q   <= (op_in == OP_TLBWR) ? random_q : index_q[IW-1:0];
                        wd_vpn2 <= vpn2_q;
                        wd_asid <= asid_q;
                        wd_lo0  <= lo0_q;
                        wd_lo1  <= lo1_q;
                    end
                end
                S_EXEC: begin
                    state  <= S_DONE;
                    we_q   <= 1'b0;
                    done_q <= 1'b1;
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // CP0 registers; later assignments win, giving capture > exception > MTC0.
    always_ff @(posedge clk) begin
        if (reset) begin
            index_q  <= '0;
            random_q <= IDX_MAX;
            lo0_q    <= '0;
            lo1_q    <= '0;
            vpn2_q   <= '0;
            asid_q   <= '0;
        end else begin
            if (wired_wr || (random_q == wired_v)) random_q <= IDX_MAX;
            else                                   random_q <= random_q - IDX_ONE;

            if (reg_we) begin
                case (reg_addr)
                    5'd0:  index_q[IW-1:0] <= reg_wdata[IW-1:0];
                    5'd2:  lo0_q <= reg_wdata[25:0];
                    5'd3:  lo1_q <= reg_wdata[25:0];
                    5'd10: begin
                        vpn2_q <= reg_wdata[31:13];
                        asid_q <= reg_wdata[7:0];
                    end
                    default: ;
                endcase
            end

            if (exc_we) vpn2_q <= exc_vaddr[31:13];

            if (state == S_EXEC && op_q == OP_TLBR) begin
                vpn2_q <= tlb.tlbrw_rdata.vpn2;
                asid_q <= tlb.tlbrw_rdata.asid;
                lo0_q  <= tlb.tlbrw_rdata.entry_lo0;
                lo1_q  <= tlb.tlbrw_rdata.entry_lo1;
            end
            if (state == S_EXEC && op_q == OP_TLBP) index_q <= tlb.tlbp_index;
        end
    end

    // MFC0 read mux; unimplemented bits and registers read as zero.
    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            5'd0:  reg_rdata = index_q;
            5'd1:  reg_rdata[IW-1:0] = random_q;
            5'd2:  reg_rdata[25:0] = lo0_q;
            5'd3:  reg_rdata[25:0] = lo1_q;
            5'd6:  reg_rdata[IW-1:0] = wired_v;
            5'd10: reg_rdata = {vpn2_q, 5'b0, asid_q};
            default: ;
        endcase
    end

    // A write strobe pending when reset arrives must never reach the TLB.
    assign tlb.tlbrw_we      = we_q & ~reset;
    assign tlb.op_ready      = ready_q;
    assign tlb.op_done       = done_q;
    assign tlb.tlbrw_index   = idx_q;
    assign tlb.tlbrw_wdata   = {wd_vpn2, wd_asid, 16'h0000, wd_lo0, wd_lo1};
    assign tlb.asid          = asid_q;
    assign tlb.tlbp_entry_hi = {vpn2_q, 5'b0, asid_q};

    logic unused_bits;
    assign unused_bits = ^{reg_wdata[12:8], exc_vaddr[12:0], tlb.tlbrw_rdata.page_mask};
endmodule

// File: tb/tb_cp0_tlb_ctrl.sv
// Bench for cp0_tlb_ctrl: directed stimulus, a cycle-level register/TLB model
// compared against the DUT every cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_cp0_tlb_ctrl;
    localparam int N  = 16;
    localparam int IW = 4;
`ifdef TLB_WIRED_EN
    localparam bit WIRED = 1'b1;
`else
    localparam bit WIRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_we = 1'b0;
    logic [4:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        exc_we = 1'b0;
    logic [31:0] exc_vaddr = '0;
    logic [31:0] tb_tlbp = '0;

    int errors = 0;
    int checks = 0;

    cp0_tlb_ctrl_if #(.TLB_ENTRIES(N)) tif ();

    cp0_tlb_ctrl #(.TLB_ENTRIES(N)) dut (
        .clk(clk), .reset(reset), .tlb(tif),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .exc_we(exc_we), .exc_vaddr(exc_vaddr)
    );

    always #5 clk = ~clk;

    // TLB array standing in for the slave side.
    logic [94:0] slave_mem [N] = '{default: '0};
    always @(posedge clk) if (tif.tlbrw_we) slave_mem[tif.tlbrw_index] <= tif.tlbrw_wdata;
    assign tif.tlbrw_rdata = slave_mem[tif.tlbrw_index];
    assign tif.tlbp_index  = tb_tlbp;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [31:0]   m_index, m_hi, m_lo0, m_lo1, m_wired;
    logic [IW-1:0] m_random, m_target, lower;
    logic [1:0]    m_type;
    logic [31:0]   s_hi, s_lo0, s_lo1;
    logic [31:0]   t_hi [N] = '{default: '0};
    logic [31:0]   t_lo0 [N] = '{default: '0};
    logic [31:0]   t_lo1 [N] = '{default: '0};
    bit            busy = 0, model_ok = 0, cap_r, cap_p, exp_we;
    int            phase = 0;

    function automatic logic [31:0] mread(input logic [4:0] a);
        case (a)
            5'd0:  return m_index;
            5'd1:  return 32'(m_random);
            5'd2:  return m_lo0;
            5'd3:  return m_lo1;
            5'd6:  return m_wired;
            5'd10: return m_hi;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        cap_r = 0;
        cap_p = 0;
        if (reset) begin
            m_index = 0; m_hi = 0; m_lo0 = 0; m_lo1 = 0; m_wired = 0;
            m_random = IW'(N - 1);
            busy = 0; phase = 0; model_ok = 1;
        end else begin
            lower = WIRED ? m_wired[IW-1:0] : '0;
            if (busy) begin
                if (phase == 1) begin
                    if (m_type == 2'd1 || m_type == 2'd2) begin
                        t_hi[m_target] = s_hi; t_lo0[m_target] = s_lo0; t_lo1[m_target] = s_lo1;
                    end else if (m_type == 2'd0) cap_r = 1;
                    else cap_p = 1;
                    phase = 2;
                end else begin
                    busy = 0; phase = 0;
                end
            end else if (tif.op_valid) begin
                busy = 1; phase = 1; m_type = tif.op_type;
                m_target = (tif.op_type == 2'd2) ? m_random : m_index[IW-1:0];
                s_hi = m_hi; s_lo0 = m_lo0; s_lo1 = m_lo1;
            end
            if (WIRED && reg_we && reg_addr == 5'd6) m_random = IW'(N - 1);
            else if (m_random == lower)              m_random = IW'(N - 1);
            else                                     m_random = m_random - 1'b1;
            if (reg_we) begin
                case (reg_addr)
                    5'd0:  m_index[IW-1:0] = reg_wdata[IW-1:0];
                    5'd2:  m_lo0 = reg_wdata & 32'h03FF_FFFF;
                    5'd3:  m_lo1 = reg_wdata & 32'h03FF_FFFF;
                    5'd6:  if (WIRED) m_wired = reg_wdata & (N - 1);
                    5'd10: m_hi = reg_wdata & 32'hFFFF_E0FF;
                    default: ;
                endcase
            end
            if (exc_we) m_hi[31:13] = exc_vaddr[31:13];
            if (cap_r) begin
                m_hi = t_hi[m_target]; m_lo0 = t_lo0[m_target]; m_lo1 = t_lo1[m_target];
            end
            if (cap_p) m_index = tb_tlbp;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            exp_we = busy && phase == 1 && (m_type == 2'd1 || m_type == 2'd2) && !reset;
            chk("op_ready", 32'(tif.op_ready), 32'(!busy));
            chk("op_done", 32'(tif.op_done), 32'(busy && phase == 2));
            chk("tlbrw_we", 32'(tif.tlbrw_we), 32'(exp_we));
            if (exp_we) begin
                chk("tlbrw_index", 32'(tif.tlbrw_index), 32'(m_target));
                chk("wdata_hi", {tif.tlbrw_wdata.vpn2, 5'b0, tif.tlbrw_wdata.asid}, s_hi);
                chk("wdata_lo0", 32'(tif.tlbrw_wdata.entry_lo0), s_lo0);
                chk("wdata_lo1", 32'(tif.tlbrw_wdata.entry_lo1), s_lo1);
                chk("wdata_mask", 32'(tif.tlbrw_wdata.page_mask), 32'h0);
            end
            chk("reg_rdata", reg_rdata, mread(reg_addr));
            chk("asid", 32'(tif.asid), 32'(m_hi[7:0]));
            chk("tlbp_entry_hi", tif.tlbp_entry_hi, m_hi);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_we = 1'b0;
    endtask

    // Returns in the EXEC cycle of the accepted request.
    task automatic issue_op(input logic [1:0] t);
        int guard;
        guard = 0;
        tif.op_valid = 1'b1;
        tif.op_type  = t;
        while (!tif.op_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL op_accept_timeout got=busy exp=ready");
        end
        tick();
        tif.op_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tif.op_valid = 1'b0;
        tif.op_type  = 2'd0;
        tick();
        tick();
        reset    = 1'b0;
        reg_addr = 5'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("rst_ready", 32'(tif.op_ready), 32'h1);
                chk("rst_done", 32'(tif.op_done), 32'h0);
                chk("rst_we", 32'(tif.tlbrw_we), 32'h0);
                chk("rst_asid", 32'(tif.asid), 32'h0);
                chk("rst_entry_hi", tif.tlbp_entry_hi, 32'h0);
            end
            chk("random_seq", reg_rdata, 32'((31 - i) % 16));
        end
        tick();

        // TLBWI of index 5
        mtc0(5'd10, 32'h1234_56AB);
        mtc0(5'd2, 32'h0000_001F);
        mtc0(5'd0, 32'd5);
        issue_op(2'd1);
        @(negedge clk);
        chk("wi_we", 32'(tif.tlbrw_we), 32'h1);
        chk("wi_index", 32'(tif.tlbrw_index), 32'd5);
        chk("wi_asid", 32'(tif.asid), 32'hAB);
        tick();
        @(negedge clk);
        chk("wi_done", 32'(tif.op_done), 32'h1);
        chk("wi_we_off", 32'(tif.tlbrw_we), 32'h0);
        tick();
        @(negedge clk);
        chk("wi_ready", 32'(tif.op_ready), 32'h1);
        tick();

        // TLBR of index 5 after clearing EntryHi
        mtc0(5'd10, 32'h0);
        reg_addr = 5'd10;
        issue_op(2'd0);
        tick();
        @(negedge clk);
        chk("tlbr_hi", reg_rdata, 32'h1234_40AB);
        tick();
        reg_addr = 5'd2;
        @(negedge clk);
        chk("tlbr_lo0", reg_rdata, 32'h0000_001F);
        tick();

        // TLBP: miss, then hit at 3
        tb_tlbp  = 32'h8000_0000;
        reg_addr = 5'd0;
        issue_op(2'd3);
        tick();
        @(negedge clk);
        chk("tlbp_miss", reg_rdata, 32'h8000_0000);
        tick();
        tb_tlbp = 32'd3;
        issue_op(2'd3);
        tick();
        @(negedge clk);
        chk("tlbp_hit", reg_rdata, 32'd3);
        tick();

        // exc_we and MTC0 EntryHi together: VPN2 from exc_vaddr
        reg_we = 1'b1; reg_addr = 5'd10; reg_wdata = 32'hAAAA_A0CD;
        exc_we = 1'b1; exc_vaddr = 32'h5555_5123;
        tick();
        reg_we = 1'b0; exc_we = 1'b0;
        @(negedge clk);
        chk("exc_vpn2", reg_rdata & 32'hFFFF_E000, 32'h5555_4000);
        tick();

        // TLBR capture beats a same-cycle exception update
        mtc0(5'd0, 32'd5);
        issue_op(2'd0);
        exc_we = 1'b1; exc_vaddr = 32'hFFFF_F000;
        tick();
        exc_we = 1'b0;
        reg_addr = 5'd10;
        @(negedge clk);
        chk("cap_over_exc", reg_rdata, 32'h1234_40AB);
        tick();

        // PageMask and unmapped addresses
        mtc0(5'd5, 32'hFFFF_FFFF);
        reg_addr = 5'd5;
        @(negedge clk);
        chk("pagemask_zero", reg_rdata, 32'h0);
        tick();

        // Reset during EXEC of a TLBWI, then TLBWR from the reset Random
        mtc0(5'd0, 32'd7);
        issue_op(2'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_we", 32'(tif.tlbrw_we), 32'h0);
        tick();
        reset = 1'b0;
        tif.op_valid = 1'b1;
        tif.op_type  = 2'd2;
        @(negedge clk);
        chk("rst_mid_done", 32'(tif.op_done), 32'h0);
        chk("rst_mid_ready", 32'(tif.op_ready), 32'h1);
        tick();
        tif.op_valid = 1'b0;
        @(negedge clk);
        chk("wr_we", 32'(tif.tlbrw_we), 32'h1);
        chk("wr_index", 32'(tif.tlbrw_index), 32'd15);
        chk("rst_no_write7", 32'(slave_mem[7] != '0), 32'h0);
        tick();
        tick();
        tick();

`ifdef TLB_WIRED_EN
        mtc0(5'd6, 32'd4);
        reg_addr = 5'd1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("wired_random", reg_rdata, 32'((k <= 11) ? (15 - k) : (27 - k)));
        end
        tick();
        issue_op(2'd2);
        @(negedge clk);
        chk("wired_wr_index", 32'(tif.tlbrw_index), 32'd13);
        tick();
        reg_addr = 5'd6;
        @(negedge clk);
        chk("wired_read", reg_rdata, 32'd4);
        tick();
        tick();
`else
        mtc0(5'd6, 32'd4);
        reg_addr = 5'd6;
        @(negedge clk);
        chk("wired_absent", reg_rdata, 32'h0);
        tick();
        reg_addr = 5'd1;
        for (int k = 0; k < 18; k++) tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cp0_tlb_ctrl.md
# cp0_tlb_ctrl

Initiator side of the TLB maintenance interface: holds the CP0 TLB registers (Index, Random, EntryLo0/1, PageMask, Wired, EntryHi) and sequences TLBR/TLBWI/TLBWR/TLBP requests from the pipeline into the TLB's `tlbrw_*` and `tlbp_*` ports. It sits beside CP0 in the MEM stage, drives the current ASID to the TLB, and accepts MTC0/MFC0 accesses and exception-time EntryHi updates.

## Interface
- `TLB_ENTRIES`, default `` `TLB_ENTRIES_NUM `` (16): number of TLB entries; power of two; IW = $clog2(TLB_ENTRIES).

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `op_valid`  in  1  TLB instruction request
- `op_type`  in  2  0=TLBR, 1=TLBWI, 2=TLBWR, 3=TLBP
- `op_ready`  out  1  high only in IDLE
- `op_done`  out  1  one-cycle completion pulse
- `reg_we`  in  1  MTC0 write strobe
- `reg_addr`  in  5  CP0 register number
- `reg_wdata`  in  32  MTC0 data
- `reg_rdata`  out  32  MFC0 data, combinational from `reg_addr`
- `exc_we`  in  1  TLB exception: load EntryHi VPN2
- `exc_vaddr`  in  32  faulting virtual address
- `asid`  out  8  EntryHi[7:0], to TLB
- `tlbrw_index`  out  tlb_index_t  entry selector
- `tlbrw_we`  out  1  entry write strobe
- `tlbrw_wdata`  out  tlb_entry_t  packed from EntryHi/EntryLo0/EntryLo1/PageMask
- `tlbrw_rdata`  in  tlb_entry_t  entry read data
- `tlbp_entry_hi`  out  32  always equal to EntryHi
- `tlbp_index`  in  32  probe result {miss, zeros, index}

## Operation
- Register map (`reg_addr`): 0 Index, 1 Random, 2 EntryLo0, 3 EntryLo1, 5 PageMask, 6 Wired, 10 EntryHi; other addresses read 0, writes ignored.
- Write masks: Index [IW-1:0] (P bit [31] not MTC0-writable); Random read-only; EntryLo0/1 [25:0]; PageMask always 0 (4 KB pages only); Wired [IW-1:0]; EntryHi [31:13] and [7:0]. Unwritable bits read 0.
- FSM: IDLE → EXEC → DONE → IDLE. Accept when `op_valid && op_ready` in IDLE; latch `op_type` and, for TLBWR, the current Random value as the target.
- EXEC: TLBWI drives `tlbrw_index`=Index[IW-1:0], `tlbrw_we`=1; TLBWR drives latched Random, `tlbrw_we`=1; TLBR drives Index and captures `tlbrw_rdata` into EntryHi/EntryLo0/EntryLo1 (PageMask stays 0); TLBP captures all 32 bits of `tlbp_index` into Index, including P.
- DONE: `op_done`=1; updated registers are visible on `reg_rdata`.
- Random: decrements every cycle; when equal to Wired (or to 0 without wired support) the next value is TLB_ENTRIES-1. An MTC0 to Wired sets Random to TLB_ENTRIES-1 in the next cycle.
- `exc_we`: EntryHi[31:13] ← `exc_vaddr[31:13]`; ASID unchanged.
- Priority on the same cycle to the same register: TLBR/TLBP capture > `exc_we` > MTC0.

## Timing
- Reset: state IDLE, `op_ready`=1, `op_done`=0, `tlbrw_we`=0; Index, EntryLo0/1, PageMask, Wired, EntryHi = 0; Random = TLB_ENTRIES-1; `asid`=0; `tlbp_entry_hi`=0.
- Request accepted at cycle T: EXEC at T+1 (`tlbrw_we` high exactly this cycle for writes), `op_done` at T+2, `op_ready` high again at T+3.
- `tlbrw_we` is never high outside EXEC; `tlbrw_index` and `tlbrw_wdata` are valid whenever `tlbrw_we`=1.
- `op_valid` while `op_ready`=0 is ignored; the requester holds the request until accepted.
- Reset asserted mid-operation: return to IDLE next cycle; no write is issued after reset is seen; a captured result from a pending TLBR/TLBP is discarded.
- MTC0 to EntryHi/EntryLo during EXEC of a write: the entry receives the pre-write values.

## Configuration
- `TLB_WIRED_EN` defined: Wired register implemented; Random cycles over [Wired, TLB_ENTRIES-1].
- Not defined: Wired reads 0, writes are ignored (no Random reload), and Random cycles over [0, TLB_ENTRIES-1].

## Test plan
- Reset, then idle 20 cycles with TLB_ENTRIES=16 → Random reads 15, 14, …, 0, 15, …; all outputs at their reset values in the first cycle.
- MTC0 EntryHi=0x12345_6AB, EntryLo0=0x0000_1F, Index=5; TLBWI at T → `tlbrw_we`=1 only at T+1 with index 5; `op_done` at T+2; `asid`=0xAB.
- TLBR of index 5 after overwriting EntryHi with 0 → EntryHi reads 0x12344_0AB (VPN2 masked) at T+2.
- TLBP: `tlbp_index`=0x8000_0000 → Index reads 0x8000_0000; `tlbp_index`=3 → Index reads 3.
- `TLB_WIRED_EN`: MTC0 Wired=4 → Random=15 next cycle, then wraps 4→15; TLBWR uses Random sampled at the accept cycle.
- Reset asserted at T+1 of a TLBWI → no `tlbrw_we` pulse, no `op_done`; `exc_we` and MTC0 EntryHi in the same cycle → VPN2 from `exc_vaddr`.
